// File: rtl/watch_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
// Latency: n/a (constants, types and an elaboration-time helper only).
// Backpressure: n/a.
// Contents: BCD digit width, converter FSM state encoding, power-of-ten helper.
package watch_pkg;

  // Bits per BCD digit.
  localparam int BCD_W = 4;

  // Converter control states.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // 10^n, evaluated at elaboration time to size the overflow limit.
  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more.
// Latency: purely combinational.
// Backpressure: none.
// Ports: din  - scratch digit before the shift
//        dout - corrected digit, ready to be shifted left by one bit
module bcd_add3
  import watch_pkg::*;
(
  input  logic [BCD_W-1:0] din,
  output logic [BCD_W-1:0] dout
);

  assign dout = (din >= BCD_W'(5)) ? din + BCD_W'(3) : din;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: WIDTH-bit unsigned binary to DIGITS BCD digits.
// Latency: exactly WIDTH cycles from the start-sampling edge to the done edge.
// Backpressure: start is ignored while busy; results hold until the next done.
// Ports: clk, rst_n (async active-low)
//        start, bin        - request and operand, sampled together while idle
//        busy              - conversion in progress
//        done              - one-cycle pulse when bcd/lz/ovf update
//        bcd, lz, ovf      - packed BCD result, leading-zero mask, range overflow
module bin2bcd_seq
  import watch_pkg::*;
#(
  parameter int WIDTH  = 7,
  parameter int DIGITS = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [WIDTH-1:0]        bin,
  output logic                    busy,
  output logic                    done,
  output logic [BCD_W*DIGITS-1:0] bcd,
  output logic [DIGITS-1:0]       lz,
  output logic                    ovf
);

  localparam int          SW    = BCD_W * DIGITS;
  localparam int          CNT_W = $clog2(WIDTH + 1);
  // Largest value representable in DIGITS decimal digits.
  localparam logic [31:0] LIMIT = 32'(pow10(DIGITS) - 1);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   bin_sr;
  logic [SW-1:0]      scratch;
  logic               ovf_cap;

  logic [SW-1:0]      adj;
  logic [SW+WIDTH-1:0] cat_shl;
  logic [SW-1:0]      scratch_nxt;
  logic [WIDTH-1:0]   bin_nxt;
  logic [DIGITS-1:0]  lz_nxt;
  logic [31:0]        bin_ext;
  logic               ovf_in;
  logic               last;
  logic               accept;
  logic               zero_above;

  // Per-digit add-3 correction ahead of each shift.
  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (scratch[g*BCD_W +: BCD_W]),
      .dout (adj[g*BCD_W +: BCD_W])
    );
  end

  // One combined left shift of scratch:binary. The carry out of the top
  // digit falls off the end, which is the intended discard on overflow.
  assign cat_shl     = {adj, bin_sr} << 1;
  assign scratch_nxt = cat_shl[SW+WIDTH-1:WIDTH];
  assign bin_nxt     = cat_shl[WIDTH-1:0];

  // Range check is done once at capture so the result path only needs a flag.
  assign bin_ext = 32'(bin);
  assign ovf_in  = bin_ext > LIMIT;

  assign busy = (state == SHIFT);

  // Leading-zero mask of the result about to be registered. Digit 0 is never
  // blanked so that a zero value still shows one digit.
  always_comb begin
    lz_nxt     = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above & (scratch_nxt[i*BCD_W +: BCD_W] == '0);
      lz_nxt[i]  = zero_above;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next-state and control strobes.
  always_comb begin
    state_nxt = state;
    last      = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == CNT_W'(WIDTH - 1)) begin
          last      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      bin_sr  <= '0;
      scratch <= '0;
      ovf_cap <= 1'b0;
      done    <= 1'b0;
      bcd     <= '0;
      lz      <= '0;
      ovf     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        cnt     <= '0;
        bin_sr  <= bin;
        scratch <= '0;
        ovf_cap <= ovf_in;
      end else if (state == SHIFT) begin
        cnt     <= cnt + CNT_W'(1);
        bin_sr  <= bin_nxt;
        scratch <= scratch_nxt;
        if (last) begin
          done <= 1'b1;
          ovf  <= ovf_cap;
          // An out-of-range value reports a blank, zero result.
          bcd  <= ovf_cap ? '0 : scratch_nxt;
          lz   <= ovf_cap ? '0 : lz_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: default 7-bit/2-digit and 8-bit/3-digit builds.
// Latency: checks exactly WIDTH cycles per conversion, back-to-back acceptance.
// Backpressure: checks start is ignored while busy and reset aborts a conversion.
module tb_bin2bcd_seq;

  logic        clk;
  logic        rst_n;

  logic        start_a, start_b;
  logic [6:0]  bin_a;
  logic [7:0]  bin_b;
  logic        busy_a, busy_b, done_a, done_b, ovf_a, ovf_b;
  logic [7:0]  bcd_a;
  logic [11:0] bcd_b;
  logic [1:0]  lz_a;
  logic [2:0]  lz_b;

  bin2bcd_seq #(.WIDTH(7), .DIGITS(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .bin(bin_a),
    .busy(busy_a), .done(done_a), .bcd(bcd_a), .lz(lz_a), .ovf(ovf_a)
  );

  bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .bin(bin_b),
    .busy(busy_b), .done(done_b), .bcd(bcd_b), .lz(lz_b), .ovf(ovf_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Selected DUT view (0: 7/2 build, 1: 8/3 build).
  logic        sel;
  logic        o_busy, o_done, o_ovf;
  logic [19:0] o_bcd;
  logic [4:0]  o_lz;
  assign o_busy = sel ? busy_b : busy_a;
  assign o_done = sel ? done_b : done_a;
  assign o_ovf  = sel ? ovf_b  : ovf_a;
  assign o_bcd  = sel ? 20'(bcd_b) : 20'(bcd_a);
  assign o_lz   = sel ? 5'(lz_b)   : 5'(lz_a);

  int n_checks = 0;
  int n_fail   = 0;
  logic [19:0] last_bcd [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (sel=%0d t=%0t)", tag, got, exp, sel, $time);
    end
  endtask

  function automatic int p10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  // Reference: decimal digits by division; blank on out-of-range values.
  function automatic logic [19:0] ref_bcd(input int v, input int nd);
    logic [19:0] r;
    r = '0;
    if (v <= p10(nd) - 1)
      for (int i = 0; i < nd; i++) r[4*i +: 4] = 4'((v / p10(i)) % 10);
    return r;
  endfunction

  // Digit i and everything above it are zero exactly when v < 10^i.
  function automatic logic [4:0] ref_lz(input int v, input int nd);
    logic [4:0] r;
    r = '0;
    if (v <= p10(nd) - 1)
      for (int i = 1; i < nd; i++) r[i] = (v < p10(i));
    return r;
  endfunction

  // Issue one conversion on the selected DUT starting in the current cycle
  // and check busy, latency and result. Returns just after the done edge.
  task automatic convert(input int v);
    int w, nd, cyc;
    logic busy_ok;
    w  = sel ? 8 : 7;
    nd = sel ? 3 : 2;
    if (sel) begin start_b = 1'b1; bin_b = 8'(v); end
    else     begin start_a = 1'b1; bin_a = 7'(v); end
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
    busy_ok = o_busy;
    check("hold", 32'(o_bcd), 32'(last_bcd[sel]));
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (o_done) break;
      if (!o_busy) busy_ok = 1'b0;
    end
    check("done_seen", 32'(o_done), 32'd1);
    check("latency", cyc, w);
    check("busy_during", 32'(busy_ok), 32'd1);
    check("busy_drop", 32'(o_busy), 32'd0);
    check("bcd", 32'(o_bcd), 32'(ref_bcd(v, nd)));
    check("lz", 32'(o_lz), 32'(ref_lz(v, nd)));
    check("ovf", 32'(o_ovf), 32'(v > p10(nd) - 1));
    last_bcd[sel] = ref_bcd(v, nd);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone, v;
    logic [19:0] seen_bcd;
    rst_n = 1'b0; sel = 1'b0;
    start_a = 1'b0; start_b = 1'b0; bin_a = '0; bin_b = '0;
    last_bcd[0] = '0; last_bcd[1] = '0;
    #2;
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_bcd", 32'(bcd_a), 32'd0);
    check("rst_lz", 32'(lz_a), 32'd0);
    check("rst_ovf", 32'(ovf_a), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed values on the 7-bit/2-digit build.
    sel = 1'b0;
    convert(59);
    @(posedge clk); #1;
    check("done_pulse", 32'(done_a), 32'd0);
    convert(0);
    convert(7);
    convert(99);
    convert(100);
    convert(127);

    // Start while busy is ignored.
    start_a = 1'b1; bin_a = 7'd42;
    @(posedge clk); #1 start_a = 1'b0;
    repeat (2) @(posedge clk);
    #1 start_a = 1'b1; bin_a = 7'd13;
    @(posedge clk); #1 start_a = 1'b0;
    ndone = 0; seen_bcd = '0;
    for (int i = 0; i < 14; i++) begin
      if (done_a) begin ndone++; seen_bcd = 20'(bcd_a); end
      @(posedge clk); #1;
    end
    check("ignored_start_dones", ndone, 1);
    check("ignored_start_bcd", 32'(seen_bcd), 32'h42);
    last_bcd[0] = 20'h42;

    // Back-to-back: second start in the done cycle.
    convert(42);
    convert(13);

    // Reset mid-conversion aborts with no done.
    start_a = 1'b1; bin_a = 7'd77;
    @(posedge clk); #1 start_a = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy_a), 32'd0);
    check("abort_done", 32'(done_a), 32'd0);
    check("abort_bcd", 32'(bcd_a), 32'd0);
    check("abort_lz", 32'(lz_a), 32'd0);
    check("abort_ovf", 32'(ovf_a), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    last_bcd[0] = '0; last_bcd[1] = '0;
    convert(88);

    // Random values with random idle gaps.
    for (int i = 0; i < 40; i++) begin
      v = int'($urandom_range(0, 127));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
      convert(v);
    end

    // 8-bit/3-digit build: directed then exhaustive.
    sel = 1'b1;
    @(posedge clk); #1;
    convert(255);
    convert(5);
    for (int i = 0; i < 256; i++) convert(i);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 Parameter WIDTH, default 7, binary input width in bits (legal range 4..16).
REQ-002 Parameter DIGITS, default 2, number of BCD output digits (legal range 1..5).
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 start  input  1  conversion request; sampled only while idle.
REQ-006 bin  input  WIDTH  unsigned binary value; sampled in the same cycle as start.
REQ-007 busy  output  1  high while a conversion is in progress.
REQ-008 done  output  1  one-cycle pulse; bcd, lz and ovf are valid from this cycle onward.
REQ-009 bcd  output  4*DIGITS  packed BCD result; digit i occupies bits [4i+3:4i], with digit 0 the least significant.
REQ-010 lz  output  DIGITS  leading-zero mask; bit i high means digit i is a leading zero (display blanking).
REQ-011 ovf  output  1  high when the last sampled bin exceeded 10^DIGITS-1.

Function
REQ-012 The FSM SHALL have two states: IDLE and SHIFT.
REQ-013 IDLE: if start=1 at edge k, capture bin, clear the DIGITS-digit scratch register, set the shift counter to 0, go to SHIFT, and set busy=1 from edge k.
REQ-014 SHIFT, each edge: add 3 to every scratch digit >=5, then shift scratch:binary left by one bit (MSB of binary first), and increment the counter.
REQ-015 The edge completing the WIDTH-th shift (edge k+WIDTH) SHALL register bcd, lz and ovf, set done=1 and busy=0, and return to IDLE.
REQ-016 Latency from the start-sampling edge to the done edge SHALL be exactly WIDTH cycles, independent of value.
REQ-017 done SHALL be high for exactly one cycle per accepted start.
REQ-018 start SHALL be ignored while busy=1; no queuing; the in-flight conversion is unaffected.
REQ-019 start=1 in the cycle done=1 (state IDLE) SHALL be accepted; back-to-back conversions therefore run without idle gaps.
REQ-020 ovf = (captured bin > 10^DIGITS-1), with the limit computed as an elaboration-time local constant.
REQ-021 When ovf=1, bcd and lz SHALL be all zeros, and the full WIDTH-cycle latency SHALL still apply.
REQ-022 Overflow handling: digit carries out of the top scratch digit SHALL be discarded.
REQ-023 lz[DIGITS-1:1]: bit i high iff digit i and all higher digits are 0; lz[0] SHALL always be 0, so a value of 0 shows one digit.
REQ-024 bcd, lz and ovf SHALL hold their last registered values until the next done; they SHALL NOT change during SHIFT.

Reset
REQ-025 On rst_n=0, asynchronously: state=IDLE, busy=0, done=0, bcd=0, lz=0, ovf=0, counter and scratch=0.
REQ-026 Reset asserted mid-conversion SHALL abort it with no done pulse; after release the block SHALL accept start on the first rising edge.

Structure
REQ-027 The shared package watch_pkg SHALL hold the BCD digit-width constant (4) and the FSM state encoding (IDLE, SHIFT).
REQ-028 Sub-module bcd_add3 (4-bit in, 4-bit out, combinational add-3-if->=5) SHALL be instantiated DIGITS times via generate.
REQ-029 Counter width SHALL be the minimum needed to count to WIDTH; there SHALL be no combinational path from start or bin to any output.

Verification
REQ-030 Default parameters, bin=59, start pulse -> busy high for 7 cycles, then done with bcd=8'h59, lz=2'b00, ovf=0.
REQ-031 bin=0 -> bcd=8'h00, lz=2'b10, ovf=0; bin=7 -> bcd=8'h07, lz=2'b10.
REQ-032 bin=99 -> bcd=8'h99, ovf=0; bin=100 and bin=127 -> bcd=8'h00, lz=2'b00, ovf=1, done still after 7 cycles.
REQ-033 Start with bin=42, then start with bin=13 three cycles later -> only one done, bcd=8'h42; start with bin=13 in the done cycle -> second done 7 cycles later with bcd=8'h13.
REQ-034 rst_n low for 1 cycle mid-conversion -> no done, all outputs 0; next start with bin=88 -> bcd=8'h88.
REQ-035 WIDTH=8, DIGITS=3: bin=255 -> bcd=12'h255 after 8 cycles; bin=5 -> lz=3'b110; exhaustive sweep 0..255 against a reference model.
